seq_run_logger: RTL

- Downstream consumer of the serial-pattern detector's level output Y.
- Measures each contiguous Y-high run in clock cycles and queues the run lengths in a small FIFO, which is drained by a valid/ready reader.
- Maintains a saturating count of completed runs and a sticky overflow flag for runs dropped while the FIFO was full.

---
 rtl/seq_run_logger.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_run_logger.sv
// Measures each contiguous Y-high run in clock cycles and queues the lengths in a
// small FIFO drained by a valid/ready reader; counts completed runs and flags drops.
module seq_run_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Y,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN_W-1:0] out_len,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             complete;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full, pop, push_ok, drop;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    complete  = 1'b0;
    if (clr) begin
      // A run already in progress when clr hits is waited out in DISCARD, never logged.
      state_nxt = Y ? DISCARD : IDLE;
      len_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (Y) begin
            state_nxt = RUN;
            len_nxt   = LEN_W'(1);
          end
        end
        RUN: begin
          if (Y) begin
            if (len != '1) len_nxt = len + 1'b1;
          end else begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
        DISCARD: begin
          if (!Y) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign full      = (occ == OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly where the tail points.
  assign push_ok   = complete && (!full || pop);
  assign drop      = complete && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: storage is not reset; out_len is masked by occupancy so stale words never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= len;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_count <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      evt_count <= '0;
      ovf       <= 1'b0;
    end else begin
      if (complete && evt_count != '1) evt_count <= evt_count + 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

  assign out_len = out_valid ? mem[rd_ptr] : '0;
  assign busy    = (state == RUN);

endmodule
